// File: rtl/array_multiplier_pkg.sv
// Shared constants and Baugh-Wooley helpers for the signed array multiplier.
package array_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int PROD_W        = 2 * DEFAULT_WIDTH;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Bit weights that receive the constant correction one in the modified Baugh-Wooley sum.
    function automatic int corr_pos_low(input int w);
        return w;
    endfunction

    function automatic int corr_pos_high(input int w);
        return 2 * w - 1;
    endfunction

    function automatic logic bw_corr_bit(input int pos, input int w);
        return (pos == corr_pos_low(w)) || (pos == corr_pos_high(w));
    endfunction

    // Full correction constant as a value, for reference by datapaths that fold it elsewhere.
    function automatic longint unsigned bw_corr_const(input int w);
        return (64'd1 << corr_pos_low(w)) | (64'd1 << corr_pos_high(w));
    endfunction

endpackage

// File: rtl/array_multiplier_if.sv
// Operand/product bundle for the signed array multiplier; master drives operands, slave returns the product.
interface array_multiplier_if
    import array_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic signed [2*WIDTH-1:0] product;

    modport master (output a, output b, input product);
    modport slave  (input a, input b, output product);
endinterface

// File: rtl/array_multiplier_cell.sv
// Array cell: partial-product AND (optionally NAND for sign terms) feeding a full adder.
module array_multiplier_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic invert,
    input  logic sum_in,
    input  logic carry_in,
    output logic sum_out,
    output logic carry_out
);
    logic pp;

    assign pp        = (a_bit & b_bit) ^ invert;
    assign sum_out   = pp ^ sum_in ^ carry_in;
    assign carry_out = (pp & sum_in) | (pp & carry_in) | (sum_in & carry_in);
endmodule

// File: rtl/array_multiplier.sv
// Registered signed Baugh-Wooley carry-save array multiplier (1-cycle latency).
// Define ARRAY_MULTIPLIER_INREG_EN to register A/B before the array (2-cycle latency).
module array_multiplier
    import array_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    output logic signed [2*WIDTH-1:0] PRODUCT,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic                      clk,
    input  logic                      rst
);
    localparam int N  = WIDTH;
    localparam int PW = prod_width(WIDTH);

    logic [N-1:0] a_op;
    logic [N-1:0] b_op;

`ifdef ARRAY_MULTIPLIER_INREG_EN
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end

    assign a_op = a_q;
    assign b_op = b_q;
`else
    assign a_op = A;
    assign b_op = B;
`endif

    // Carry-save grid: cell (i,j) has weight i+j; s_w/c_w are flattened row-major.
    logic s_w [N*N];
    logic c_w [N*N];
    logic rs_w [N];
    logic rc_w [N-1];
    logic top_carry_unused;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam logic INV  = logic'((i == N-1) != (j == N-1));
            localparam logic CORR = bw_corr_bit(i + N - 1, N);
            logic sin;
            logic cin;

            if (i == 0) begin : g_first
                assign sin = 1'b0;
                assign cin = 1'b0;
            end else if (j < N-1) begin : g_mid
                assign sin = s_w[(i-1)*N + j + 1];
                assign cin = c_w[(i-1)*N + j];
            end else begin : g_edge
                // Leftmost column has no shifted sum from above; the low correction one enters here.
                assign sin = CORR;
                assign cin = c_w[(i-1)*N + j];
            end

            array_multiplier_cell u_cell (
                .a_bit     (a_op[j]),
                .b_bit     (b_op[i]),
                .invert    (INV),
                .sum_in    (sin),
                .carry_in  (cin),
                .sum_out   (s_w[i*N + j]),
                .carry_out (c_w[i*N + j])
            );
        end
    end

    // Final ripple-carry row merges the last sum/carry vectors into bits N..2N-1.
    for (genvar j = 0; j < N; j++) begin : g_final
        localparam logic CORR_TOP = bw_corr_bit(N + j, N);
        logic sin;
        logic cin;

        if (j < N-1) begin : g_sum
            assign sin = s_w[(N-1)*N + j + 1];
        end else begin : g_top
            assign sin = CORR_TOP;
        end

        if (j == 0) begin : g_cin0
            assign cin = 1'b0;
        end else begin : g_cinr
            assign cin = rc_w[j-1];
        end

        if (j < N-1) begin : g_ripple
            array_multiplier_cell u_cell (
                .a_bit     (c_w[(N-1)*N + j]),
                .b_bit     (1'b1),
                .invert    (1'b0),
                .sum_in    (sin),
                .carry_in  (cin),
                .sum_out   (rs_w[j]),
                .carry_out (rc_w[j])
            );
        end else begin : g_msb
            array_multiplier_cell u_cell (
                .a_bit     (c_w[(N-1)*N + j]),
                .b_bit     (1'b1),
                .invert    (1'b0),
                .sum_in    (sin),
                .carry_in  (cin),
                .sum_out   (rs_w[j]),
                .carry_out (top_carry_unused)
            );
        end
    end

    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q;

    always_comb begin
        prod_d = '0;
        for (int k = 0; k < N; k++) begin
            prod_d[k]     = s_w[k*N];
            prod_d[N + k] = rs_w[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign PRODUCT = $signed(prod_q);
endmodule

// File: tb/tb_array_multiplier.sv
// Scoreboard bench for array_multiplier: driver queues expected products, monitor checks each edge.
module tb_array_multiplier;
    localparam int W = 4;

    typedef struct {
        logic signed [2*W-1:0] exp;
        string                 tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    array_multiplier_if #(.WIDTH(W)) ifc ();

    array_multiplier #(.WIDTH(W)) dut (
        .PRODUCT (ifc.product),
        .A       (ifc.a),
        .B       (ifc.b),
        .clk     (clk),
        .rst     (rst)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

`ifdef ARRAY_MULTIPLIER_INREG_EN
    exp_t dly = '{exp: '0, tag: "init"};
`endif

    // Queue what PRODUCT must show after the next rising edge.
    task automatic drive(input logic r, input int a, input int b, input int hand, input string tag);
        exp_t cur;
        exp_t out;
        @(negedge clk);
        rst   = r;
        ifc.a = 4'(a);
        ifc.b = 4'(b);
        cur.exp = r ? '0 : 8'(hand);
        cur.tag = tag;
`ifdef ARRAY_MULTIPLIER_INREG_EN
        if (r) begin
            out = cur;
        end else begin
            out = dly;
        end
        dly = cur;
`else
        out = cur;
`endif
        sb.push_back(out);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (ifc.product !== e.exp) begin
                n_fails++;
                $display("FAIL %s: PRODUCT=%0d (0x%02h) expected %0d (0x%02h) at %0t",
                         e.tag, ifc.product, ifc.product, e.exp, e.exp, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [W-1:0] ta;
        logic signed [W-1:0] tb;
        int va;
        int vb;

        ifc.a = '0;
        ifc.b = '0;

        // Reset with live operands, then release.
        drive(1'b1, 7, 7, 0, "reset_hold0");
        drive(1'b1, 7, 7, 0, "reset_hold1");
        drive(1'b0, 7, 7, 49, "reset_release");
        drive(1'b0, 7, 7, 49, "reset_release_b");

        // Sign corners.
        drive(1'b0, -8, -8, 64, "neg8_neg8");
        drive(1'b0, -8, 7, -56, "neg8_pos7");
        drive(1'b0, 7, -8, -56, "pos7_neg8");
        drive(1'b0, -1, -1, 1, "neg1_neg1");
        drive(1'b0, -1, 1, -1, "neg1_pos1");

        // Zero and identity.
        drive(1'b0, 0, -8, 0, "zero_neg8");
        drive(1'b0, 5, 0, 0, "five_zero");
        drive(1'b0, 1, -5, -5, "one_neg5");
        drive(1'b0, -5, 1, -5, "neg5_one");

        // Back-to-back streaming.
        drive(1'b0, 3, 4, 12, "stream0");
        drive(1'b0, -2, 6, -12, "stream1");
        drive(1'b0, -7, -7, 49, "stream2");

        // Mid-stream reset for one edge.
        drive(1'b0, 2, 3, 6, "pre_rst");
        drive(1'b1, 7, 7, 0, "mid_rst");
        drive(1'b0, 4, 4, 16, "post_rst0");
        drive(1'b0, -3, 5, -15, "post_rst1");
        drive(1'b0, 6, -6, -36, "post_rst2");

        // Exhaustive sweep against the golden signed product.
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                drive(1'b0, a, b, a * b, "sweep");
            end
        end

        // Out-of-range drivers truncated to WIDTH bits.
        for (int k = 0; k < 1000; k++) begin
            va = int'($urandom_range(0, 32)) - 16;
            vb = int'($urandom_range(0, 32)) - 16;
            ta = 4'(va);
            tb = 4'(vb);
            drive(1'b0, va, vb, int'(ta) * int'(tb), "random");
        end

        drive(1'b0, 0, 0, 0, "flush0");
        drive(1'b0, 0, 0, 0, "flush1");

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
